// File: rtl/multicycle_cpu_core_if.sv
// Instruction/operand input stream for multicycle_cpu_core (valid/ready handshake).
// The producer drives data and valid; the core answers with ready.
interface multicycle_cpu_core_if #(
  parameter int unsigned DATA_W = 10
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/multicycle_cpu_core.sv
// Multi-cycle single-bus CPU core: IR, T0..T3 step FSM, register file, A/G ALU regs, Z/C flags.
// Define CPU_MUL_EN to decode opcode 9 as MUL; otherwise opcode 9 is illegal.
module multicycle_cpu_core #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned NREG   = 4,
  localparam int unsigned RA_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rstb,
  multicycle_cpu_core_if.slave in_if,
  input  logic [RA_W-1:0]   peek_addr,
  output logic [DATA_W-1:0] peek_data,
  output logic [DATA_W-1:0] bus_out,
  output logic [1:0]        step,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic              flag_c
);

  // IR keeps only opcode and the two register fields; the low bits carry no meaning.
  localparam int unsigned IR_W = 4 + 2 * RA_W;

  typedef enum logic [1:0] {StT0 = 2'd0, StT1 = 2'd1, StT2 = 2'd2, StT3 = 2'd3} step_e;

  localparam logic [3:0] OpLd  = 4'd0;
  localparam logic [3:0] OpMv  = 4'd1;
  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpSub = 4'd3;
  localparam logic [3:0] OpAnd = 4'd4;
  localparam logic [3:0] OpOr  = 4'd5;
  localparam logic [3:0] OpXor = 4'd6;
  localparam logic [3:0] OpShl = 4'd7;
  localparam logic [3:0] OpShr = 4'd8;
`ifdef CPU_MUL_EN
  localparam logic [3:0] OpMul = 4'd9;
`endif

  step_e             step_q, step_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] regs_q [NREG];

  logic              wr_en;
  logic [RA_W-1:0]   wr_idx;
  logic [DATA_W-1:0] wr_data;

  logic [3:0]        opcode;
  logic [RA_W-1:0]   rx, ry;
  logic              is_alu;
  logic [DATA_W-1:0] bus;
  logic              in_ready;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
`ifdef CPU_MUL_EN
  logic [2*DATA_W-1:0] prod;
`endif

  assign opcode = ir_q[IR_W-1 -: 4];
  assign rx     = ir_q[2*RA_W-1 -: RA_W];
  assign ry     = ir_q[RA_W-1:0];

  always_comb begin
    is_alu = 1'b0;
    case (opcode)
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShl, OpShr: is_alu = 1'b1;
`ifdef CPU_MUL_EN
      OpMul: is_alu = 1'b1;
`endif
      default: is_alu = 1'b0;
    endcase
  end

  // Internal bus source select; illegal opcodes drive zero.
  always_comb begin
    bus = '0;
    unique case (step_q)
      StT0: bus = in_if.in_data;
      StT1: begin
        if (opcode == OpLd) begin
          bus = in_if.in_data;
        end else if (opcode == OpMv) begin
          bus = regs_q[ry];
        end else if (is_alu) begin
          bus = regs_q[rx];
        end
      end
      StT2: bus = regs_q[ry];
      StT3: bus = g_q;
    endcase
  end

  // ALU: A is the left operand, the bus (Ry during T2) the right one.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
`ifdef CPU_MUL_EN
    prod    = '0;
`endif
    case (opcode)
      OpAdd: {alu_c, alu_res} = {1'b0, a_q} + {1'b0, bus};
      OpSub: begin
        alu_res = a_q - bus;
        alu_c   = (a_q >= bus);
      end
      OpAnd: alu_res = a_q & bus;
      OpOr:  alu_res = a_q | bus;
      OpXor: alu_res = a_q ^ bus;
      OpShl: begin
        alu_res = {a_q[DATA_W-2:0], 1'b0};
        alu_c   = a_q[DATA_W-1];
      end
      OpShr: begin
        alu_res = {1'b0, a_q[DATA_W-1:1]};
        alu_c   = a_q[0];
      end
`ifdef CPU_MUL_EN
      OpMul: begin
        prod    = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, bus};
        alu_res = prod[DATA_W-1:0];
        alu_c   = |prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  always_comb begin
    step_d   = step_q;
    ir_d     = ir_q;
    a_d      = a_q;
    g_d      = g_q;
    z_d      = z_q;
    c_d      = c_q;
    err_d    = err_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = rx;
    wr_data  = bus;
    in_ready = 1'b0;
    unique case (step_q)
      StT0: begin
        in_ready = 1'b1;
        if (in_if.in_valid) begin
          ir_d   = in_if.in_data[DATA_W-1 -: IR_W];
          step_d = StT1;
        end
      end
      StT1: begin
        if (opcode == OpLd) begin
          in_ready = 1'b1;
          if (in_if.in_valid) begin
            wr_en  = 1'b1;
            step_d = StT0;
            done_d = 1'b1;
          end
        end else if (opcode == OpMv) begin
          wr_en  = 1'b1;
          step_d = StT0;
          done_d = 1'b1;
        end else if (is_alu) begin
          a_d    = bus;
          step_d = StT2;
        end else begin
          err_d  = 1'b1;
          step_d = StT0;
          done_d = 1'b1;
        end
      end
      StT2: begin
        g_d    = alu_res;
        z_d    = (alu_res == '0);
        c_d    = alu_c;
        step_d = StT3;
      end
      StT3: begin
        wr_en  = 1'b1;
        step_d = StT0;
        done_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      step_q <= StT0;
      ir_q   <= '0;
      a_q    <= '0;
      g_q    <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
      a_q    <= a_d;
      g_q    <= g_d;
      z_q    <= z_d;
      c_q    <= c_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  assign in_if.in_ready = in_ready;
  assign peek_data      = regs_q[peek_addr];
  assign bus_out        = bus;
  assign step           = step_q;
  assign done           = done_q;
  assign err            = err_q;
  assign flag_z         = z_q;
  assign flag_c         = c_q;

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Scoreboard bench for multicycle_cpu_core: stimulus queues expected retire states and
// per-cycle traces; a negedge monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_multicycle_cpu_core;

  localparam int unsigned DW = 10;

  logic          clk = 1'b0;
  logic          rstb;
  logic [1:0]    peek_addr;
  logic [DW-1:0] peek_data;
  logic [DW-1:0] bus_out;
  logic [1:0]    step;
  logic          done, err, flag_z, flag_c;

  always #5 clk = ~clk;

  multicycle_cpu_core_if #(.DATA_W(DW)) in_if ();

  multicycle_cpu_core #(.DATA_W(DW), .NREG(4)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .in_if     (in_if),
    .peek_addr (peek_addr),
    .peek_data (peek_data),
    .bus_out   (bus_out),
    .step      (step),
    .done      (done),
    .err       (err),
    .flag_z    (flag_z),
    .flag_c    (flag_c)
  );

  typedef struct packed {
    logic [3:0][DW-1:0] r;
    logic               z;
    logic               c;
    logic               e;
  } st_t;

  typedef struct packed {
    logic [1:0]    stp;
    logic [DW-1:0] bus;
    logic          rdy;
    logic          dn;
    logic          has_st;
    st_t           st;
  } tr_t;

  st_t state_q[$];
  tr_t trace_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic st_t mk(input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                             input logic [DW-1:0] r2, input logic [DW-1:0] r3,
                             input logic z, input logic c, input logic e);
    st_t s;
    s.r[0] = r0;
    s.r[1] = r1;
    s.r[2] = r2;
    s.r[3] = r3;
    s.z    = z;
    s.c    = c;
    s.e    = e;
    return s;
  endfunction

  function automatic tr_t mt(input logic [1:0] s, input logic [DW-1:0] b, input logic rdy,
                             input logic dn);
    tr_t t;
    t.stp    = s;
    t.bus    = b;
    t.rdy    = rdy;
    t.dn     = dn;
    t.has_st = 1'b0;
    t.st     = '0;
    return t;
  endfunction

  // Sweeps the peek port across all registers, then checks flags and ERR.
  task automatic check_state(input string tag, input st_t e);
    for (int i = 0; i < 4; i++) begin
      peek_addr = 2'(i);
      #0.5;
      chk($sformatf("%s R%0d", tag, i), peek_data, e.r[i]);
    end
    chk({tag, " Z"}, flag_z, e.z);
    chk({tag, " C"}, flag_c, e.c);
    chk({tag, " ERR"}, err, e.e);
  endtask

  initial begin : monitor
    tr_t t;
    st_t s;
    int  ntr;
    int  ndone;
    ntr   = 0;
    ndone = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (trace_q.size() > 0) begin
          t = trace_q.pop_front();
          ntr++;
          chk($sformatf("trace%0d STEP", ntr), step, t.stp);
          chk($sformatf("trace%0d BUS", ntr), bus_out, t.bus);
          chk($sformatf("trace%0d READY", ntr), in_if.in_ready, t.rdy);
          chk($sformatf("trace%0d DONE", ntr), done, t.dn);
          if (t.has_st) check_state($sformatf("trace%0d", ntr), t.st);
        end
        if (done === 1'b1) begin
          ndone++;
          if (state_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got DONE=1 at pulse %0d expected no pulse", ndone);
          end else begin
            s = state_q.pop_front();
            check_state($sformatf("retire%0d", ndone), s);
          end
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] w);
    int n;
    n = 0;
    in_if.in_data  = w;
    in_if.in_valid = 1'b1;
    while (in_if.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got READY=0 for 20 cycles expected READY=1");
    end
    @(posedge clk);
    #1;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
  endtask

  // Waits for the retire pulse, then leaves one idle cycle so the DONE cycle sees BUS=0.
  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got DONE=0 for 20 cycles expected DONE=1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [DW-1:0] w, input st_t e);
    state_q.push_back(e);
    send(w);
    wait_done();
  endtask

  task automatic ld(input logic [1:0] rd, input logic [DW-1:0] val, input st_t e);
    state_q.push_back(e);
    send({4'h0, rd, 4'h0});
    send(val);
    wait_done();
  endtask

  initial begin : stimulus
    tr_t t;
    rstb           = 1'b0;
    in_if.in_data  = '0;
    in_if.in_valid = 1'b0;
    peek_addr      = '0;
    repeat (2) @(posedge clk);
    #1;
    t        = mt(2'd0, 10'h000, 1'b1, 1'b0);
    t.has_st = 1'b1;
    t.st     = mk(10'h0, 10'h0, 10'h0, 10'h0, 1'b0, 1'b0, 1'b0);
    trace_q.push_back(t);
    mon_en = 1'b1;
    rstb   = 1'b1;
    @(posedge clk);
    #1;

    ld(2'd0, 10'h3FF, mk(10'h3FF, 10'h000, 10'h0, 10'h0, 1'b0, 1'b0, 1'b0));
    ld(2'd1, 10'h001, mk(10'h3FF, 10'h001, 10'h0, 10'h0, 1'b0, 1'b0, 1'b0));

    // ADD R0,R1 with the full step/bus trace from the fetch cycle to the DONE cycle.
    trace_q.push_back(mt(2'd0, 10'h084, 1'b1, 1'b0));
    trace_q.push_back(mt(2'd1, 10'h3FF, 1'b0, 1'b0));
    trace_q.push_back(mt(2'd2, 10'h001, 1'b0, 1'b0));
    trace_q.push_back(mt(2'd3, 10'h000, 1'b0, 1'b0));
    trace_q.push_back(mt(2'd0, 10'h000, 1'b1, 1'b1));
    ins(10'h084, mk(10'h000, 10'h001, 10'h0, 10'h0, 1'b1, 1'b1, 1'b0));

    ins(10'h0D0, mk(10'h000, 10'h001, 10'h0, 10'h0, 1'b0, 1'b1, 1'b0));
    ins(10'h0C4, mk(10'h3FF, 10'h001, 10'h0, 10'h0, 1'b0, 1'b0, 1'b0));

    trace_q.push_back(mt(2'd0, 10'h3C0, 1'b1, 1'b0));
    trace_q.push_back(mt(2'd1, 10'h000, 1'b0, 1'b0));
    trace_q.push_back(mt(2'd0, 10'h000, 1'b1, 1'b1));
    ins(10'h3C0, mk(10'h3FF, 10'h001, 10'h0, 10'h0, 1'b0, 1'b0, 1'b1));

    ins(10'h060, mk(10'h3FF, 10'h001, 10'h3FF, 10'h000, 1'b0, 1'b0, 1'b1));
    ins(10'h1E0, mk(10'h3FF, 10'h001, 10'h3FE, 10'h000, 1'b0, 1'b1, 1'b1));
    ins(10'h210, mk(10'h3FF, 10'h000, 10'h3FE, 10'h000, 1'b1, 1'b1, 1'b1));
    ld(2'd3, 10'h0F0, mk(10'h3FF, 10'h000, 10'h3FE, 10'h0F0, 1'b1, 1'b1, 1'b1));
    ins(10'h138, mk(10'h3FF, 10'h000, 10'h3FE, 10'h0F0, 1'b0, 1'b0, 1'b1));
    ins(10'h15C, mk(10'h3FF, 10'h0F0, 10'h3FE, 10'h0F0, 1'b0, 1'b0, 1'b1));
    ins(10'h194, mk(10'h3FF, 10'h000, 10'h3FE, 10'h0F0, 1'b1, 1'b0, 1'b1));

    // LD R0 with the operand withheld for five cycles: must sit in T1 without writing.
    state_q.push_back(mk(10'h2AA, 10'h000, 10'h3FE, 10'h0F0, 1'b1, 1'b0, 1'b1));
    send(10'h000);
    in_if.in_data = 10'h155;
    for (int i = 0; i < 5; i++) begin
      t = mt(2'd1, 10'h155, 1'b1, 1'b0);
      if (i == 4) begin
        t.has_st = 1'b1;
        t.st     = mk(10'h3FF, 10'h000, 10'h3FE, 10'h0F0, 1'b1, 1'b0, 1'b1);
      end
      trace_q.push_back(t);
    end
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    send(10'h2AA);
    wait_done();

    // Reset asserted during ADD T2 aborts the instruction and clears everything.
    trace_q.push_back(mt(2'd0, 10'h084, 1'b1, 1'b0));
    trace_q.push_back(mt(2'd1, 10'h2AA, 1'b0, 1'b0));
    trace_q.push_back(mt(2'd2, 10'h000, 1'b0, 1'b0));
    send(10'h084);
    @(posedge clk);
    #1;
    rstb = 1'b0;
    @(posedge clk);
    #1;
    rstb     = 1'b1;
    t        = mt(2'd0, 10'h000, 1'b1, 1'b0);
    t.has_st = 1'b1;
    t.st     = mk(10'h0, 10'h0, 10'h0, 10'h0, 1'b0, 1'b0, 1'b0);
    trace_q.push_back(t);
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    ld(2'd0, 10'h003, mk(10'h003, 10'h000, 10'h0, 10'h0, 1'b0, 1'b0, 1'b0));
    ld(2'd1, 10'h005, mk(10'h003, 10'h005, 10'h0, 10'h0, 1'b0, 1'b0, 1'b0));
`ifdef CPU_MUL_EN
    ins(10'h244, mk(10'h00F, 10'h005, 10'h0, 10'h0, 1'b0, 1'b0, 1'b0));
`else
    ins(10'h244, mk(10'h003, 10'h005, 10'h0, 10'h0, 1'b0, 1'b0, 1'b1));
`endif

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pending_retires", state_q.size(), 0);
    chk("pending_traces", trace_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish after 200000ns expected finish");
    $fatal(1);
  end

endmodule
